// File: rtl/shift_reg_univ_if.sv
// -----------------------------------------------------------------------------
// shift_reg_univ_if
//   Bus bundle for the universal shift register (shift_reg_univ).
//   Clock and reset are not part of the bundle; they stay plain ports on the
//   register itself.
//
//   Parameters (must match the shift_reg_univ instance attached to it):
//     DATA_W  bits per stage
//     DEPTH   number of stages
//
//   Signals:
//     en        update enable
//     mode      00 hold, 01 fwd shift, 10 rev shift, 11 parallel load
//     sin_fwd   serial input entering stage 0 on a fwd shift
//     sin_rev   serial input entering stage DEPTH-1 on a rev shift
//     pload     parallel load word, stage k = pload[k*DATA_W +: DATA_W]
//     rotate    (only with SHIFT_REG_ROTATE_EN) recirculate instead of sin_*
//     sout_fwd  stage DEPTH-1
//     sout_rev  stage 0
//     pout      all stages, same packing as pload
//     fill_cnt  stages written since reset, 0..DEPTH
//     full      fill_cnt == DEPTH
//
//   Optional feature macro: SHIFT_REG_ROTATE_EN
// -----------------------------------------------------------------------------
interface shift_reg_univ_if #(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                      en;
  logic [1:0]                mode;
  logic [DATA_W-1:0]         sin_fwd;
  logic [DATA_W-1:0]         sin_rev;
  logic [DEPTH*DATA_W-1:0]   pload;
`ifdef SHIFT_REG_ROTATE_EN
  logic                      rotate;
`endif
  logic [DATA_W-1:0]         sout_fwd;
  logic [DATA_W-1:0]         sout_rev;
  logic [DEPTH*DATA_W-1:0]   pout;
  logic [CNT_W-1:0]          fill_cnt;
  logic                      full;

  // Driver side (the user of the register).
  modport master (
`ifdef SHIFT_REG_ROTATE_EN
    output rotate,
`endif
    output en, mode, sin_fwd, sin_rev, pload,
    input  sout_fwd, sout_rev, pout, fill_cnt, full
  );

  // Register side.
  modport slave (
`ifdef SHIFT_REG_ROTATE_EN
    input  rotate,
`endif
    input  en, mode, sin_fwd, sin_rev, pload,
    output sout_fwd, sout_rev, pout, fill_cnt, full
  );
endinterface

// File: rtl/shift_reg_univ.sv
// -----------------------------------------------------------------------------
// shift_reg_univ
//   Parametrised universal shift register: DEPTH stages of DATA_W bits with
//   hold, forward shift, reverse shift and parallel load. Serial and parallel
//   outputs are all registered and available simultaneously. An occupancy
//   counter (fill_cnt / full) tracks how many stages have been written since
//   reset.
//
//   Parameters:
//     DATA_W  bits per stage (>=1)
//     DEPTH   number of stages (>=2)
//     CNT_W   derived width of fill_cnt, $clog2(DEPTH+1)
//
//   Ports:
//     Clk   rising-edge clock
//     rst   synchronous reset, active-high; beats en and mode
//     bus   shift_reg_univ_if.slave: en, mode, sin_fwd, sin_rev, pload,
//           [rotate], sout_fwd, sout_rev, pout, fill_cnt, full
//
//   Optional feature macro: SHIFT_REG_ROTATE_EN
//     Adds bus.rotate. With rotate=1 a fwd shift feeds the old last stage back
//     into stage 0 and a rev shift feeds the old stage 0 into the last stage;
//     fill_cnt is left unchanged on such edges. Ignored in hold and load.
// -----------------------------------------------------------------------------
module shift_reg_univ #(
  parameter int unsigned DATA_W = 1,
  parameter int unsigned DEPTH  = 4
) (
  input  logic             Clk,
  input  logic             rst,
  shift_reg_univ_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_FWD  = 2'b01,
    MODE_REV  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  // stage[k] sits at bit slice k*DATA_W +: DATA_W, matching pload/pout.
  logic [DEPTH-1:0][DATA_W-1:0] stage;
  logic [DEPTH-1:0][DATA_W-1:0] stage_nxt;
  logic [CNT_W-1:0]             fill_cnt;
  logic [CNT_W-1:0]             cnt_nxt;
  logic [CNT_W-1:0]             cnt_bump;
  logic                         full;
  logic                         full_nxt;
  logic                         rot;
  mode_t                        mode;

  assign mode = mode_t'(bus.mode);

`ifdef SHIFT_REG_ROTATE_EN
  assign rot = bus.rotate;
`else
  assign rot = 1'b0;
`endif

  // Saturating increment used by every non-rotating shift.
  assign cnt_bump = (fill_cnt == CNT_MAX) ? CNT_MAX : fill_cnt + 1'b1;

  always_comb begin
    stage_nxt = stage;
    cnt_nxt   = fill_cnt;
    if (bus.en) begin
      case (mode)
        MODE_FWD: begin
          // Stages move towards higher indices; stage 0 takes the new entry.
          if (rot) begin
            stage_nxt = {stage[DEPTH-2:0], stage[DEPTH-1]};
          end else begin
            stage_nxt = {stage[DEPTH-2:0], bus.sin_fwd};
            cnt_nxt   = cnt_bump;
          end
        end
        MODE_REV: begin
          // Stages move towards lower indices; the last stage takes the entry.
          if (rot) begin
            stage_nxt = {stage[0], stage[DEPTH-1:1]};
          end else begin
            stage_nxt = {bus.sin_rev, stage[DEPTH-1:1]};
            cnt_nxt   = cnt_bump;
          end
        end
        MODE_LOAD: begin
          stage_nxt = bus.pload;
          cnt_nxt   = CNT_MAX;
        end
        default: begin
          stage_nxt = stage;
          cnt_nxt   = fill_cnt;
        end
      endcase
    end
    // full is registered from the same next-count so it rises with fill_cnt.
    full_nxt = (cnt_nxt == CNT_MAX);
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      stage    <= '0;
      fill_cnt <= '0;
      full     <= 1'b0;
    end else begin
      stage    <= stage_nxt;
      fill_cnt <= cnt_nxt;
      full     <= full_nxt;
    end
  end

  assign bus.sout_fwd = stage[DEPTH-1];
  assign bus.sout_rev = stage[0];
  assign bus.pout     = stage;
  assign bus.fill_cnt = fill_cnt;
  assign bus.full     = full;

endmodule

// File: tb/tb_shift_reg_univ.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_univ
//   Bench for shift_reg_univ. Two instances: defaults (DATA_W=1, DEPTH=4) and
//   DATA_W=8, DEPTH=3. A vector table exercises the default instance, short
//   hand-written sequences cover the wide instance and the rotate option
//   (SHIFT_REG_ROTATE_EN), then random stimulus drives both instances against
//   an arithmetic reference model of the register contents.
// -----------------------------------------------------------------------------
module tb_shift_reg_univ;

  logic Clk = 1'b0;
  logic rst_a, rst_b;
  always #5 Clk = ~Clk;

  shift_reg_univ_if #(.DATA_W(1), .DEPTH(4)) bus_a ();
  shift_reg_univ_if #(.DATA_W(8), .DEPTH(3)) bus_b ();

  shift_reg_univ #(.DATA_W(1), .DEPTH(4)) u_dut_a (.Clk(Clk), .rst(rst_a), .bus(bus_a));
  shift_reg_univ #(.DATA_W(8), .DEPTH(3)) u_dut_b (.Clk(Clk), .rst(rst_b), .bus(bus_b));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  // Reference model: register contents as one integer, stage 0 in the LSBs.
  function automatic void model_step(input int dw, input int dp, input bit r, input bit en,
                                     input bit [1:0] md, input bit rot,
                                     input longint unsigned sf, input longint unsigned sr,
                                     input longint unsigned pl,
                                     inout longint unsigned v, inout int c);
    longint unsigned mask, lane;
    int top;
    mask = (64'd1 << (dw * dp)) - 1;
    lane = (64'd1 << dw) - 1;
    top  = (dp - 1) * dw;
    if (r) begin v = 0; c = 0; return; end
    if (!en) return;
    case (md)
      2'd1: if (rot) v = ((v << dw) | (v >> top)) & mask;
            else begin v = ((v << dw) | sf) & mask; c = (c + 1 > dp) ? dp : c + 1; end
      2'd2: if (rot) v = (v >> dw) | ((v & lane) << top);
            else begin v = (v >> dw) | (sr << top); c = (c + 1 > dp) ? dp : c + 1; end
      2'd3: begin v = pl & mask; c = dp; end
      default: ;
    endcase
  endfunction

  typedef struct {
    bit       r;
    bit       en;
    bit [1:0] md;
    bit       sf;
    bit       sr;
    bit [3:0] pl;
    bit [3:0] ep;
    int       ec;
    bit       ef;
  } vec_t;

  vec_t tbl[$];

  task automatic drive_a(input bit r, input bit en, input bit [1:0] md, input bit sf,
                         input bit sr, input bit [3:0] pl, input bit rot);
    rst_a = r; bus_a.en = en; bus_a.mode = md;
    bus_a.sin_fwd = sf; bus_a.sin_rev = sr; bus_a.pload = pl;
`ifdef SHIFT_REG_ROTATE_EN
    bus_a.rotate = rot;
`else
    if (rot) $display("note: rotate requested without rotate support");
`endif
  endtask

  task automatic check_a(input string tag, input bit [3:0] ep, input int ec, input bit ef);
    chk({tag, "_pout"}, bus_a.pout, ep);
    chk({tag, "_cnt"}, bus_a.fill_cnt, ec);
    chk({tag, "_full"}, bus_a.full, ef);
    chk({tag, "_soutf"}, bus_a.sout_fwd, ep[3]);
    chk({tag, "_soutr"}, bus_a.sout_rev, ep[0]);
  endtask

  task automatic drive_b(input bit r, input bit en, input bit [1:0] md, input bit [7:0] sf,
                         input bit [7:0] sr, input bit [23:0] pl, input bit rot);
    rst_b = r; bus_b.en = en; bus_b.mode = md;
    bus_b.sin_fwd = sf; bus_b.sin_rev = sr; bus_b.pload = pl;
`ifdef SHIFT_REG_ROTATE_EN
    bus_b.rotate = rot;
`else
    if (rot) $display("note: rotate requested without rotate support");
`endif
  endtask

  initial begin
    longint unsigned ma, mb;
    int ca, cb;
    // {rst, en, mode, sin_fwd, sin_rev, pload, exp_pout, exp_cnt, exp_full}
    tbl.push_back('{1, 0, 2'b00, 0, 0, 4'b0000, 4'b0000, 0, 0}); // reset
    tbl.push_back('{0, 1, 2'b01, 1, 0, 4'b0000, 4'b0001, 1, 0}); // fwd 1
    tbl.push_back('{0, 1, 2'b01, 0, 0, 4'b0000, 4'b0010, 2, 0}); // fwd 0
    tbl.push_back('{0, 1, 2'b01, 1, 0, 4'b0000, 4'b0101, 3, 0}); // fwd 1
    tbl.push_back('{0, 1, 2'b01, 1, 0, 4'b0000, 4'b1011, 4, 1}); // fwd 1 -> full
    tbl.push_back('{0, 1, 2'b11, 0, 0, 4'b1001, 4'b1001, 4, 1}); // load
    tbl.push_back('{0, 1, 2'b10, 0, 0, 4'b0000, 4'b0100, 4, 1}); // rev 0
    tbl.push_back('{0, 1, 2'b10, 0, 0, 4'b0000, 4'b0010, 4, 1});
    tbl.push_back('{0, 1, 2'b10, 0, 0, 4'b0000, 4'b0001, 4, 1});
    tbl.push_back('{0, 1, 2'b10, 0, 0, 4'b0000, 4'b0000, 4, 1});
    tbl.push_back('{0, 1, 2'b11, 0, 0, 4'b0110, 4'b0110, 4, 1}); // load
    tbl.push_back('{0, 0, 2'b01, 1, 1, 4'b1111, 4'b0110, 4, 1}); // en=0 x5
    tbl.push_back('{0, 0, 2'b01, 0, 0, 4'b1111, 4'b0110, 4, 1});
    tbl.push_back('{0, 0, 2'b01, 1, 1, 4'b1111, 4'b0110, 4, 1});
    tbl.push_back('{0, 0, 2'b01, 0, 0, 4'b1111, 4'b0110, 4, 1});
    tbl.push_back('{0, 0, 2'b01, 1, 1, 4'b1111, 4'b0110, 4, 1});
    tbl.push_back('{0, 1, 2'b11, 0, 0, 4'b1111, 4'b1111, 4, 1}); // load ones
    tbl.push_back('{1, 1, 2'b11, 0, 0, 4'b1111, 4'b0000, 0, 0}); // rst beats load
    tbl.push_back('{0, 1, 2'b01, 1, 0, 4'b0000, 4'b0001, 1, 0}); // fwd after reset
    tbl.push_back('{0, 1, 2'b00, 0, 1, 4'b1111, 4'b0001, 1, 0}); // en=1 hold
    tbl.push_back('{0, 1, 2'b10, 0, 1, 4'b0000, 4'b1000, 2, 0}); // direction change

    drive_a(1, 0, 2'b00, 0, 0, '0, 0);
    drive_b(1, 0, 2'b00, 8'h00, 8'h00, '0, 0);
    @(posedge Clk); #1;

    foreach (tbl[i]) begin
      @(negedge Clk);
      drive_a(tbl[i].r, tbl[i].en, tbl[i].md, tbl[i].sf, tbl[i].sr, tbl[i].pl, 0);
      @(posedge Clk); #1;
      check_a($sformatf("tbl%0d", i), tbl[i].ep, tbl[i].ec, tbl[i].ef);
    end

    // Wide instance: three fwd shifts fill it.
    @(negedge Clk); drive_b(0, 1, 2'b01, 8'hA5, 8'h00, '0, 0);
    @(negedge Clk); drive_b(0, 1, 2'b01, 8'h3C, 8'h00, '0, 0);
    @(posedge Clk); #1;
    chk("b_cnt2", bus_b.fill_cnt, 2);
    chk("b_full2", bus_b.full, 0);
    @(negedge Clk); drive_b(0, 1, 2'b01, 8'hFF, 8'h00, '0, 0);
    @(posedge Clk); #1;
    chk("b_pout", bus_b.pout, 24'hA53CFF);
    chk("b_soutf", bus_b.sout_fwd, 8'hA5);
    chk("b_soutr", bus_b.sout_rev, 8'hFF);
    chk("b_cnt3", bus_b.fill_cnt, 3);
    chk("b_full3", bus_b.full, 1);
    @(negedge Clk); drive_b(0, 1, 2'b10, 8'h00, 8'h5A, '0, 0);
    @(posedge Clk); #1;
    chk("b_rev_pout", bus_b.pout, 24'h5AA53C);
    chk("b_rev_cnt", bus_b.fill_cnt, 3);

`ifdef SHIFT_REG_ROTATE_EN
    @(negedge Clk); drive_a(0, 1, 2'b11, 0, 0, 4'b0001, 0);
    @(posedge Clk); #1;
    check_a("rot_load", 4'b0001, 4, 1);
    begin
      bit [3:0] exp_rot [4];
      exp_rot[0] = 4'b0010; exp_rot[1] = 4'b0100; exp_rot[2] = 4'b1000; exp_rot[3] = 4'b0001;
      for (int k = 0; k < 4; k++) begin
        @(negedge Clk); drive_a(0, 1, 2'b01, 0, 0, 4'b0000, 1);
        @(posedge Clk); #1;
        check_a($sformatf("rotf%0d", k), exp_rot[k], 4, 1);
      end
    end
    @(negedge Clk); drive_a(0, 1, 2'b10, 0, 0, 4'b0000, 1);
    @(posedge Clk); #1;
    check_a("rotr", 4'b1000, 4, 1);
    // Rotate after reset leaves the count at zero.
    @(negedge Clk); drive_a(1, 0, 2'b00, 0, 0, 4'b0000, 0);
    @(negedge Clk); drive_a(0, 1, 2'b01, 1, 0, 4'b0000, 1);
    @(posedge Clk); #1;
    check_a("rot_empty", 4'b0000, 0, 0);
`endif

    // Random phase: both instances, first cycle forced into reset.
    ma = 0; mb = 0; ca = 0; cb = 0;
    for (int i = 0; i < 600; i++) begin
      bit r, en, rot;
      bit [1:0] md;
      bit [7:0] sf, sr;
      bit [23:0] pl;
      @(negedge Clk);
      // instance A
      r = (i == 0) || ($urandom_range(0, 40) == 0);
      en = ($urandom_range(0, 3) != 0);
      md = 2'($urandom_range(0, 3));
      sf = 8'($urandom); sr = 8'($urandom); pl = 24'($urandom);
`ifdef SHIFT_REG_ROTATE_EN
      rot = ($urandom_range(0, 3) == 0);
`else
      rot = 0;
`endif
      drive_a(r, en, md, sf[0], sr[0], pl[3:0], rot);
      model_step(1, 4, r, en, md, rot, sf[0], sr[0], pl[3:0], ma, ca);
      // instance B
      r = (i == 0) || ($urandom_range(0, 40) == 0);
      en = ($urandom_range(0, 3) != 0);
      md = 2'($urandom_range(0, 3));
      sf = 8'($urandom); sr = 8'($urandom); pl = 24'($urandom);
`ifdef SHIFT_REG_ROTATE_EN
      rot = ($urandom_range(0, 3) == 0);
`else
      rot = 0;
`endif
      drive_b(r, en, md, sf, sr, pl, rot);
      model_step(8, 3, r, en, md, rot, sf, sr, pl, mb, cb);
      @(posedge Clk); #1;
      chk($sformatf("rnd%0d_a_pout", i), bus_a.pout, ma);
      chk($sformatf("rnd%0d_a_cnt", i), bus_a.fill_cnt, ca);
      chk($sformatf("rnd%0d_a_full", i), bus_a.full, ca == 4);
      chk($sformatf("rnd%0d_a_soutf", i), bus_a.sout_fwd, (ma >> 3) & 1);
      chk($sformatf("rnd%0d_a_soutr", i), bus_a.sout_rev, ma & 1);
      chk($sformatf("rnd%0d_b_pout", i), bus_b.pout, mb);
      chk($sformatf("rnd%0d_b_cnt", i), bus_b.fill_cnt, cb);
      chk($sformatf("rnd%0d_b_full", i), bus_b.full, cb == 3);
      chk($sformatf("rnd%0d_b_soutf", i), bus_b.sout_fwd, (mb >> 16) & 8'hFF);
      chk($sformatf("rnd%0d_b_soutr", i), bus_b.sout_rev, mb & 8'hFF);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
Parametrised universal shift register: DEPTH stages, each DATA_W bits wide, with hold, forward shift, reverse shift and parallel-load modes. Serial and parallel outputs are available at the same time. An occupancy counter tracks how many stages hold written data. It is the general successor to the fixed 4-stage serial-in/serial-out chain, for serialisers, deserialisers, delay lines and data alignment.

Parameters:
DATA_W, 1, bits per stage (>=1)
DEPTH, 4, number of stages (>=2)
CNT_W, $clog2(DEPTH+1), width of fill_cnt (derived, not overridden)

Ports:
Clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
en  in  1  update enable; when low the register holds
mode  in  2  00 hold, 01 fwd shift, 10 rev shift, 11 parallel load
sin_fwd  in  DATA_W  serial input entering stage 0 on a fwd shift
sin_rev  in  DATA_W  serial input entering stage DEPTH-1 on a rev shift
pload  in  DEPTH*DATA_W  parallel load word; stage k = pload[k*DATA_W +: DATA_W]
sout_fwd  out  DATA_W  stage DEPTH-1 (fwd serial output)
sout_rev  out  DATA_W  stage 0 (rev serial output)
pout  out  DEPTH*DATA_W  all stages, same packing as pload
fill_cnt  out  CNT_W  stages written since reset, 0..DEPTH
full  out  1  fill_cnt == DEPTH

Behaviour:
- Clock and reset: one clock (Clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of Clk.
- Reset priority: rst beats en and mode. On reset, every stage = 0, fill_cnt = 0, full = 0. Because reset is synchronous, a mid-operation reset discards all contents on that edge.
- All outputs are taken directly from registers. There is no combinational path from inputs to outputs.
- en=0: all state holds, whatever mode is.
- en=1, mode 00 (hold): no change.
- en=1, mode 01 (fwd shift): stage[0] <= sin_fwd; stage[k] <= stage[k-1] for k=1..DEPTH-1. The old stage[DEPTH-1] is discarded.
  - Latency: a value applied at sin_fwd appears on sout_fwd after exactly DEPTH enabled fwd-shift edges.
- en=1, mode 10 (rev shift): stage[DEPTH-1] <= sin_rev; stage[k] <= stage[k+1] for k=0..DEPTH-2.
  - Latency: sin_rev reaches sout_rev after DEPTH enabled rev-shift edges.
- en=1, mode 11 (parallel load): all stages <= pload in one edge. Values appear on pout and on both serial outputs the next cycle.
- fill_cnt:
  - Shift (either direction): +1, saturating at DEPTH.
  - Load: set to DEPTH.
  - Hold or en=0: unchanged.
  - Direction changes do not reset the count.
- full: registered alongside fill_cnt; asserts on the same edge fill_cnt reaches DEPTH.
- Mode changes between cycles need no idle cycle. Each edge is evaluated independently.
- Widths: pout and pload are exactly DEPTH*DATA_W bits. No truncation or sign extension is applied anywhere.

Optional Feature:
Macro SHIFT_REG_ROTATE_EN.
- Defined:
  - Adds input port rotate (1 bit).
  - When rotate=1 in mode 01, stage[0] takes the old stage[DEPTH-1] instead of sin_fwd.
  - When rotate=1 in mode 10, stage[DEPTH-1] takes the old stage[0] instead of sin_rev.
  - fill_cnt is unchanged on any rotate edge.
  - rotate is ignored in modes 00 and 11.
- Not defined: the rotate port does not exist, and the serial inputs are always used.

Test Plan:
- Defaults (DATA_W=1, DEPTH=4): reset, then fwd shift sin_fwd = 1,0,1,1 on 4 edges -> fill_cnt 1,2,3,4; full rises on the 4th edge; pout=4'b1011; sout_fwd=1.
- Parallel load pload=4'b1001, then 4 rev shifts with sin_rev=0 -> sout_rev after load, then after each shift: 1,0,0,1,0; fill_cnt stays 4.
- en=0 with mode=01 and sin_fwd toggling for 5 cycles -> pout, fill_cnt and full unchanged.
- Reset mid-operation: load 4'b1111, then assert rst with en=1, mode=11 on the same edge -> pout=0, fill_cnt=0, full=0 on the next cycle.
- DATA_W=8, DEPTH=3: fwd shift 0xA5, 0x3C, 0xFF -> pout=24'hA53CFF, sout_fwd=0xA5, sout_rev=0xFF, full=1.
- SHIFT_REG_ROTATE_EN defined, defaults: load 4'b0001, one fwd shift with rotate=1 -> pout=4'b0010; 3 more rotates -> pout=4'b0001; fill_cnt=4 throughout.
